// File: rtl/tdc_pkg.sv
// Shared types and widths for the ring-oscillator TDC receive path.
package tdc_pkg;
  localparam int unsigned TDC_PHASES = 16;
  localparam int unsigned FINE_W     = 5;
  localparam int unsigned COARSE_W   = 7;
  localparam int unsigned VPH_W      = 12;

  typedef logic [VPH_W-1:0] vphase_t;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} tdcdec_state_t;
endpackage

// File: rtl/tdc_therm_decode.sv
// Popcount-based fine-phase decode of the alternately-inverted ring phase word,
// with a flag for any word that is not a clean thermometer code.
module tdc_therm_decode
  import tdc_pkg::*;
(
  input  logic [TDC_PHASES-1:0] phase_i,
  output logic [FINE_W-1:0]     fine_o,
  output logic                  bubble_o
);

  logic [FINE_W-1:0]     ones;
  logic [TDC_PHASES-1:0] norm;
  logic [TDC_PHASES:0]   norm_inc;

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < TDC_PHASES; i++) begin
      ones = ones + FINE_W'(phase_i[i]);
    end
    // Invert so both polarities become 1s-from-bit-0; a clean run of 1s plus one has no overlap.
    norm     = phase_i[0] ? phase_i : ~phase_i;
    norm_inc = {1'b0, norm} + (TDC_PHASES+1)'(1);
    bubble_o = |({1'b0, norm} & norm_inc);
    fine_o   = phase_i[0] ? (ones - FINE_W'(1)) : (FINE_W'(31) - ones);
  end

endmodule

// File: rtl/tdc_decoder.sv
// TDC receive side: input register, fine decode/alignment, phase increment,
// wrapping phase accumulator and windowed FCW measurement.
module tdc_decoder
  import tdc_pkg::*;
#(
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned CAL_LOG2 = 4,
  parameter int unsigned FINE_DLY = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [COARSE_W-1:0]       ripple_count,
  input  logic [TDC_PHASES-1:0]     phase,
  output logic                      valid,
  output logic [FINE_W-1:0]         fine,
  output logic [VPH_W-1:0]          delta,
  output logic [ACC_W-1:0]          phase_acc,
  output logic [VPH_W+CAL_LOG2-1:0] fcw_meas,
  output logic                      fcw_valid,
  output logic                      bubble_err
);

  localparam int unsigned FCW_W = VPH_W + CAL_LOG2;

  logic [COARSE_W-1:0]   rc_q;
  logic [TDC_PHASES-1:0] ph_q;
  logic [FINE_W-1:0]     fine_dec;
  logic                  bubble_dec;
  logic [FINE_W-1:0]     fine_del;
  vphase_t               var_phase;
  vphase_t               delta_n;
  vphase_t               prev_q;
  vphase_t               delta_q;
  tdcdec_state_t         state_q;
  logic                  valid_q;
  logic                  fcw_valid_q;
  logic                  bubble_q;
  logic [FINE_W-1:0]     fine_q;
  logic [ACC_W-1:0]      acc_q;
  logic [FCW_W-1:0]      fcw_q;
  logic [FCW_W-1:0]      win_q;
  logic [CAL_LOG2-1:0]   cnt_q;

  tdc_therm_decode u_therm (
    .phase_i  (ph_q),
    .fine_o   (fine_dec),
    .bubble_o (bubble_dec)
  );

  if (FINE_DLY == 0) begin : g_nodly
    assign fine_del = fine_dec;
  end else begin : g_dly
    logic [FINE_W-1:0] dly_q [FINE_DLY];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < FINE_DLY; i++) dly_q[i] <= '0;
      end else begin
        dly_q[0] <= fine_dec;
        for (int unsigned i = 1; i < FINE_DLY; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign fine_del = dly_q[FINE_DLY-1];
  end

  assign var_phase = {rc_q, fine_del};
  assign delta_n   = var_phase - prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q        <= '0;
      ph_q        <= '0;
      prev_q      <= '0;
      delta_q     <= '0;
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      fcw_valid_q <= 1'b0;
      bubble_q    <= 1'b0;
      fine_q      <= '0;
      acc_q       <= '0;
      fcw_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
    end else begin
      rc_q        <= ripple_count;
      ph_q        <= phase;
      valid_q     <= 1'b0;
      fcw_valid_q <= 1'b0;
      if (bubble_dec) bubble_q <= 1'b1;
      if (!en) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        win_q   <= '0;
      end else begin
        fine_q <= fine_del;
        case (state_q)
          IDLE: begin
            prev_q  <= var_phase;
            cnt_q   <= '0;
            win_q   <= '0;
            state_q <= PRIME;
          end
          PRIME, RUN: begin
            prev_q  <= var_phase;
            delta_q <= delta_n;
            acc_q   <= acc_q + ACC_W'(delta_n);
            valid_q <= 1'b1;
            state_q <= RUN;
            cnt_q   <= cnt_q + CAL_LOG2'(1);
            // The completing cycle's delta goes straight into the report, not into win_q.
            if (cnt_q == '1) begin
              fcw_q       <= win_q + FCW_W'(delta_n);
              fcw_valid_q <= 1'b1;
              win_q       <= '0;
            end else begin
              win_q <= win_q + FCW_W'(delta_n);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign valid      = valid_q;
  assign fine       = fine_q;
  assign delta      = delta_q;
  assign phase_acc  = acc_q;
  assign fcw_meas   = fcw_q;
  assign fcw_valid  = fcw_valid_q;
  assign bubble_err = bubble_q;

endmodule

// File: tb/tb_tdc_decoder.sv
// Self-checking bench for tdc_decoder: a true-phase oscillator model drives TDC words
// and expected increments/accumulations are derived from that phase directly.
module tb_tdc_decoder;

  localparam int unsigned ACC_W    = 24;
  localparam int unsigned CAL_LOG2 = 4;
  localparam int unsigned WIN      = 1 << CAL_LOG2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [6:0]  ripple_count;
  logic [15:0] phase;
  logic        valid;
  logic [4:0]  fine;
  logic [11:0] delta;
  logic [23:0] phase_acc;
  logic [15:0] fcw_meas;
  logic        fcw_valid;
  logic        bubble_err;

  int checks = 0;
  int errors = 0;

  longint exp_acc;
  longint exp_fcw;
  longint exp_delta;
  longint exp_fine;

  tdc_decoder #(.ACC_W(ACC_W), .CAL_LOG2(CAL_LOG2), .FINE_DLY(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ripple_count (ripple_count),
    .phase        (phase),
    .valid        (valid),
    .fine         (fine),
    .delta        (delta),
    .phase_acc    (phase_acc),
    .fcw_meas     (fcw_meas),
    .fcw_valid    (fcw_valid),
    .bubble_err   (bubble_err)
  );

  always #5 clk = ~clk;

  // Word the TDC produces for fine phase f (0..31) of the oscillator period.
  function automatic logic [15:0] word_of(input int f);
    logic [31:0] m;
    if (f < 16) m = (32'd1 << (f + 1)) - 32'd1;
    else        m = ~((32'd1 << (f - 15)) - 32'd1);
    return m[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input longint tp);
    longint c;
    c = (tp >> 5) & 127;
    ripple_count = c[6:0];
    phase        = word_of(int'(tp & 31));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step();
    rst       = 1'b0;
    exp_acc   = 0;
    exp_fcw   = 0;
    exp_delta = 0;
    exp_fine  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    drive(1234);
    step();
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid); end
    checks++; if (fine !== 5'd0) begin errors++; $display("FAIL reset_fine got %0d exp 0", fine); end
    checks++; if (delta !== 12'd0) begin errors++; $display("FAIL reset_delta got %0d exp 0", delta); end
    checks++; if (phase_acc !== 24'd0) begin errors++; $display("FAIL reset_acc got %0d exp 0", phase_acc); end
    checks++; if (fcw_meas !== 16'd0) begin errors++; $display("FAIL reset_fcw got %0d exp 0", fcw_meas); end
    checks++; if (fcw_valid !== 1'b0) begin errors++; $display("FAIL reset_fcw_valid got %0b exp 0", fcw_valid); end
    checks++; if (bubble_err !== 1'b0) begin errors++; $display("FAIL reset_bubble got %0b exp 0", bubble_err); end
    do_reset();
  endtask

  task automatic test_reset_midrun();
    longint tp;
    tp = longint'($urandom_range(0, 50000));
    en = 1'b0;
    drive(tp);
    step();
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tp += longint'($urandom_range(1, 4000));
      drive(tp);
      step();
    end
    rst = 1'b1;
    tp += 777;
    drive(tp);
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b exp 0", valid); end
    checks++; if (phase_acc !== 24'd0) begin errors++; $display("FAIL midrst_acc got %0d exp 0", phase_acc); end
    checks++; if (delta !== 12'd0) begin errors++; $display("FAIL midrst_delta got %0d exp 0", delta); end
    checks++; if (fcw_meas !== 16'd0) begin errors++; $display("FAIL midrst_fcw got %0d exp 0", fcw_meas); end
    checks++; if (fine !== 5'd0) begin errors++; $display("FAIL midrst_fine got %0d exp 0", fine); end
    rst = 1'b0;
    tp += 500;
    drive(tp);
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_prime_valid got %0b exp 0", valid); end
    tp += 500;
    drive(tp);
    step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL midrst_run_valid got %0b exp 1", valid); end
    do_reset();
  endtask

  // Free-running oscillator with per-cycle increment in [lo,hi] (1/32 periods);
  // en is held low for pause_len cycles starting at cycle pause_at.
  task automatic test_stream(input string name, input int n, input int lo, input int hi,
                             input int pause_at, input int pause_len);
    longint hist[$];
    longint tp, prev_tp, wsum;
    int     nwin;
    bit     primed, en_i;
    tp = longint'($urandom_range(0, 100000));
    en = 1'b0;
    drive(tp);
    hist.push_back(tp);
    step();
    primed = 1'b0;
    nwin   = 0;
    wsum   = 0;
    prev_tp = 0;
    for (int i = 1; i <= n; i++) begin
      en_i = !(i >= pause_at && i < pause_at + pause_len);
      tp += longint'($urandom_range(lo, hi));
      en = en_i;
      drive(tp);
      hist.push_back(tp);
      step();
      if (!en_i) begin
        primed = 1'b0;
        nwin   = 0;
        wsum   = 0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL %s idle_valid cyc %0d got %0b exp 0", name, i, valid); end
        checks++; if (fcw_valid !== 1'b0) begin errors++; $display("FAIL %s idle_fcw_valid cyc %0d got %0b exp 0", name, i, fcw_valid); end
        checks++; if (phase_acc !== exp_acc[23:0]) begin errors++; $display("FAIL %s idle_acc cyc %0d got %0d exp %0d", name, i, phase_acc, exp_acc[23:0]); end
        checks++; if (fcw_meas !== exp_fcw[15:0]) begin errors++; $display("FAIL %s idle_fcw cyc %0d got %0d exp %0d", name, i, fcw_meas, exp_fcw[15:0]); end
        checks++; if (delta !== exp_delta[11:0]) begin errors++; $display("FAIL %s idle_delta cyc %0d got %0d exp %0d", name, i, delta, exp_delta[11:0]); end
      end else begin
        exp_fine = hist[i-1] & 31;
        if (!primed) begin
          primed  = 1'b1;
          prev_tp = hist[i-1];
          checks++; if (valid !== 1'b0) begin errors++; $display("FAIL %s prime_valid cyc %0d got %0b exp 0", name, i, valid); end
          checks++; if (fcw_valid !== 1'b0) begin errors++; $display("FAIL %s prime_fcw_valid cyc %0d got %0b exp 0", name, i, fcw_valid); end
        end else begin
          exp_delta = (hist[i-1] - prev_tp) & 4095;
          prev_tp   = hist[i-1];
          exp_acc   = (exp_acc + exp_delta) & ((64'd1 << ACC_W) - 1);
          wsum     += exp_delta;
          nwin++;
          checks++; if (valid !== 1'b1) begin errors++; $display("FAIL %s valid cyc %0d got %0b exp 1", name, i, valid); end
          checks++; if (delta !== exp_delta[11:0]) begin errors++; $display("FAIL %s delta cyc %0d got %0d exp %0d", name, i, delta, exp_delta[11:0]); end
          checks++; if (phase_acc !== exp_acc[23:0]) begin errors++; $display("FAIL %s acc cyc %0d got %0d exp %0d", name, i, phase_acc, exp_acc[23:0]); end
          if (nwin == int'(WIN)) begin
            exp_fcw = wsum;
            checks++; if (fcw_valid !== 1'b1) begin errors++; $display("FAIL %s fcw_valid cyc %0d got %0b exp 1", name, i, fcw_valid); end
            checks++; if (fcw_meas !== exp_fcw[15:0]) begin errors++; $display("FAIL %s fcw_meas cyc %0d got %0d exp %0d", name, i, fcw_meas, exp_fcw[15:0]); end
            if (lo >= 1999 && hi <= 2001) begin
              checks++; if (fcw_meas < 16'd31984 || fcw_meas > 16'd32016) begin errors++; $display("FAIL %s fcw_range cyc %0d got %0d exp 32000+-16", name, i, fcw_meas); end
            end
            nwin = 0;
            wsum = 0;
          end else begin
            checks++; if (fcw_valid !== 1'b0) begin errors++; $display("FAIL %s fcw_valid cyc %0d got %0b exp 0", name, i, fcw_valid); end
          end
        end
        checks++; if (fine !== exp_fine[4:0]) begin errors++; $display("FAIL %s fine cyc %0d got %0d exp %0d", name, i, fine, exp_fine[4:0]); end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_sweep();
    logic [4:0] expf;
    en           = 1'b0;
    ripple_count = 7'd42;
    phase        = word_of(0);
    step();
    en = 1'b1;
    for (int f = 1; f <= 32; f++) begin
      phase = word_of(f % 32);
      step();
      expf = 5'(f - 1);
      checks++; if (fine !== expf) begin errors++; $display("FAIL sweep_fine step %0d got %0d exp %0d", f, fine, expf); end
    end
    checks++; if (bubble_err !== 1'b0) begin errors++; $display("FAIL sweep_bubble got %0b exp 0", bubble_err); end
    do_reset();
  endtask

  task automatic test_bubble();
    logic [15:0] w;
    logic [4:0]  expf;
    bit          legal;
    int          ones;
    en           = 1'b1;
    ripple_count = 7'd5;
    phase        = 16'h00F5;
    step();
    phase = word_of(3);
    step();
    checks++; if (bubble_err !== 1'b1) begin errors++; $display("FAIL bubble_set got %0b exp 1", bubble_err); end
    checks++; if (fine !== 5'd5) begin errors++; $display("FAIL bubble_fine got %0d exp 5", fine); end
    for (int i = 0; i < 5; i++) begin
      phase = word_of(int'($urandom_range(0, 31)));
      step();
      checks++; if (bubble_err !== 1'b1) begin errors++; $display("FAIL bubble_sticky cyc %0d got %0b exp 1", i, bubble_err); end
    end
    do_reset();
    checks++; if (bubble_err !== 1'b0) begin errors++; $display("FAIL bubble_clear got %0b exp 0", bubble_err); end
    for (int k = 0; k < 12; k++) begin
      do_reset();
      w = word_of(int'($urandom_range(0, 31)));
      if (k % 3 != 0) w = w ^ (16'd1 << $urandom_range(0, 15));
      legal = 1'b0;
      for (int f = 0; f < 32; f++) if (word_of(f) == w) legal = 1'b1;
      ones = $countones(w);
      expf = w[0] ? 5'(ones - 1) : 5'(31 - ones);
      en    = 1'b1;
      phase = w;
      step();
      phase = word_of(0);
      step();
      checks++; if (bubble_err !== !legal) begin errors++; $display("FAIL rand_bubble word %h got %0b exp %0b", w, bubble_err, !legal); end
      checks++; if (fine !== expf) begin errors++; $display("FAIL rand_fine word %h got %0d exp %0d", w, fine, expf); end
    end
    do_reset();
  endtask

  task automatic test_wrap();
    do_reset();
    en           = 1'b0;
    ripple_count = 7'd126;
    phase        = word_of(0);
    step();
    en           = 1'b1;
    ripple_count = 7'd1;
    step();
    step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %0b exp 1", valid); end
    checks++; if (delta !== 12'd96) begin errors++; $display("FAIL wrap_delta got %0d exp 96", delta); end
    checks++; if (phase_acc !== 24'd96) begin errors++; $display("FAIL wrap_acc got %0d exp 96", phase_acc); end
    step();
    checks++; if (delta !== 12'd0) begin errors++; $display("FAIL wrap_hold_delta got %0d exp 0", delta); end
    checks++; if (phase_acc !== 24'd96) begin errors++; $display("FAIL wrap_hold_acc got %0d exp 96", phase_acc); end
    do_reset();
  endtask

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    ripple_count = '0;
    phase        = '0;
    exp_acc      = 0;
    exp_fcw      = 0;
    exp_delta    = 0;
    exp_fine     = 0;
    test_reset();
    test_reset_midrun();
    test_stream("const_freq", 70, 1999, 2001, 1000, 0);
    test_stream("en_pause", 60, 1, 4095, 23, 5);
    test_stream("rand_freq", 40, 1, 4095, 1000, 0);
    test_sweep();
    test_bubble();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
